ip_psram_port: RTL
==================

Name: ip_psram_port

Overview:
Parametrised single-channel request adapter between a byte/halfword client and one channel of the Gowin PSRAM IP native interface (cmd/cmd_en/addr/32-bit wr_data/data_mask/rd_data/rd_data_valid). It replaces fixed busy-wait timing with completion-driven reads. It adds a one-deep pending request buffer, a read timeout and 8- or 16-bit client data. One instance per PSRAM channel; the top level instantiates N of them beside the IP.

Parameters:
ADDR_W, 22, client byte-address width; IP address is ADDR_W-1 bits.
DATA_W, 8, client data width, 8 or 16 only.
WRITE_WAIT, 13, write recovery cycles after cmd_en before the next command.
READ_TIMEOUT, 31, cycles after cmd_en to wait for first rd_data_valid.

Ports:
clk  in  1  single system clock; all logic on rising edge.
n_reset  in  1  asynchronous active-low reset.
init_calib  in  1  IP calibration-done flag.
initial_busy  out  1  high until calibration seen.
rd  in  1  read request pulse.
wr  in  1  write request pulse; wins over rd when both are high.
busy  out  1  port cannot accept a further request.
address  in  ADDR_W  byte address.
wdata  in  DATA_W  write data.
byte_en  in  DATA_W/8  write byte enables; DATA_W=8 ignores it and always writes.
rdata  out  DATA_W  read data.
rdata_en  out  1  one-cycle read data strobe.
timeout_err  out  1  sticky read-timeout flag.
req_overrun  out  1  sticky dropped-request flag.
cmd  out  1  IP command (1=write, 0=read).
cmd_en  out  1  IP command strobe.
addr  out  ADDR_W-1  IP halfword address, address[ADDR_W-1:1].
wr_data  out  32  IP write data.
data_mask  out  4  IP mask, 1=masked.
rd_data  in  32  IP read data.
rd_data_valid  in  1  IP read beat valid.

Behaviour:
- Reset values:
  - busy=1, initial_busy=1, cmd=0, cmd_en=0, addr=0, wr_data=0, data_mask=4'hF.
  - rdata=0, rdata_en=0, timeout_err=0, req_overrun=0.
  - Pending buffer empty; state INIT. Reset mid-operation aborts everything with no pending-command replay.
- States:
  - INIT: registered init_calib=1 leads to IDLE next cycle. initial_busy falls when entering IDLE. Requests in INIT are ignored and are not flagged. Later drops of init_calib are ignored.
  - IDLE: issues a buffered pending request first, otherwise a new rd/wr. The issue decision is made in cycle T. In T+1, cmd_en=1 for exactly one cycle with cmd/addr/wr_data/data_mask valid, and the state becomes WR_WAIT or RD_WAIT.
  - WR_WAIT: counter is loaded with WRITE_WAIT at T+1 and decremented each cycle; at 0, go to IDLE next cycle. busy low at T+2+WRITE_WAIT if nothing is pending.
  - RD_WAIT: timeout counter is loaded with READ_TIMEOUT at T+1.
    - First rd_data_valid at cycle V: capture the selected lane, rdata_en=1 at V+1, go to RD_DRAIN.
    - Counter reaching 0 with no valid: rdata_en=1 with rdata=0, timeout_err set, go to RD_DRAIN.
  - RD_DRAIN: stays while rd_data_valid=1, so later burst beats are discarded. IDLE the cycle after rd_data_valid is sampled low. For a single beat, busy is low at V+2.
- busy is registered: 1 when state!=IDLE, the pending buffer is full, or a request was issued this cycle. It is 0 only in IDLE with the buffer empty.
- Pending buffer:
  - rd/wr arriving while busy=1 (outside INIT) is stored with address/wdata/byte_en.
  - A request arriving while the buffer is full is dropped and sets req_overrun.
  - A request arriving in the same cycle the buffer issues its entry is stored (the slot frees that cycle) and does not overrun.
- Lane mapping: even byte maps to wr_data[31:24], odd byte to wr_data[23:16]. wr_data[15:0]=0 and data_mask[1:0]=2'b11 always.
  - DATA_W=8: wr_data={wdata,wdata,16'h0}. data_mask[3:2]=2'b01 when address[0]=0, 2'b10 when address[0]=1.
  - DATA_W=16: address[0] ignored. wr_data={wdata[7:0],wdata[15:8],16'h0}. data_mask[3:2]={~byte_en[0],~byte_en[1]}.
  - Read, DATA_W=8: rdata = address[0] ? rd_data[23:16] : rd_data[31:24], using the latched issue address.
  - Read, DATA_W=16: rdata={rd_data[23:16],rd_data[31:24]}.
- Outside its strobe, rdata returns to 0; cmd_en is never high on two consecutive cycles.

Test Plan:
- Calibration gate: init_calib=1 at cycle 10 after reset release -> initial_busy and busy fall at cycle 12. A rd at cycle 5 produces no cmd_en.
- Byte write, DATA_W=8: wr with address=22'h000001, wdata=8'hA5 -> next cycle cmd_en=1, cmd=1, addr=21'h0, wr_data=32'hA5A50000, data_mask=4'hB. busy low 15 cycles after request.
- Byte read: rd with address=22'h000003; IP returns a 4-beat burst with first beat rd_data=32'h12345678 -> rdata=8'h34 with a single rdata_en. busy falls 2 cycles after the last valid beat.
- Pending and overrun: wr at T, rd at T+2, wr at T+3 -> wr is issued, rd is issued after WR_WAIT, the T+3 wr is dropped and req_overrun=1. Exactly two cmd_en pulses.
- Timeout: rd with no rd_data_valid -> rdata_en with rdata=0 at T+READ_TIMEOUT+2, timeout_err=1, and a following rd is serviced normally.
- Async reset during RD_WAIT with a pending write -> all outputs at reset values immediately. After re-calibration, no replayed cmd_en.

Source files
------------

// File: rtl/ip_psram_port.sv
// ip_psram_port: one-channel request adapter onto the Gowin PSRAM native interface.
// It has a one-deep pending buffer, completion-driven reads with a timeout, and 8/16-bit client data.
module ip_psram_port #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 8,
    parameter int WRITE_WAIT   = 13,
    parameter int READ_TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                init_calib,
    output logic                initial_busy,
    input  logic                rd,
    input  logic                wr,
    output logic                busy,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_en,
    output logic                timeout_err,
    output logic                req_overrun,
    output logic                cmd,
    output logic                cmd_en,
    output logic [ADDR_W-2:0]   addr,
    output logic [31:0]         wr_data,
    output logic [3:0]          data_mask,
    input  logic [31:0]         rd_data,
    input  logic                rd_data_valid
);

    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_MAX = (WRITE_WAIT > READ_TIMEOUT) ? WRITE_WAIT : READ_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR_WAIT,
        S_RD_WAIT,
        S_RD_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                init_calib_q;
    logic                busy_q, busy_d;
    logic                initial_busy_q, initial_busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic                pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
    logic [BE_W-1:0]     pend_be_q, pend_be_d;
    logic                a0_q, a0_d;
    logic                cmd_q, cmd_d;
    logic                cmd_en_q, cmd_en_d;
    logic [ADDR_W-2:0]   addr_q, addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [3:0]          data_mask_q, data_mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_en_q, rdata_en_d;
    logic                timeout_err_q, timeout_err_d;
    logic                req_overrun_q, req_overrun_d;

    logic                req;
    logic                issue_pend;
    logic                issue_new;
    logic                issue;
    logic                store_req;
    logic                slot_free;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;
    logic [15:0]         wr_lanes;
    logic [1:0]          mask_hi;
    logic [DATA_W-1:0]   rd_lane;

    assign req        = rd | wr;
    assign issue_pend = (state_q == S_IDLE) && pend_valid_q;
    assign issue_new  = (state_q == S_IDLE) && !pend_valid_q && req;
    assign issue      = issue_pend || issue_new;
    assign store_req  = req && busy_q && (state_q != S_INIT);
    assign slot_free  = !pend_valid_q || issue_pend;

    // The buffered request always has priority over a live one.
    always_comb begin
        sel_wr    = wr;
        sel_addr  = address;
        sel_wdata = wdata;
        sel_be    = byte_en;
        if (issue_pend) begin
            sel_wr    = pend_wr_q;
            sel_addr  = pend_addr_q;
            sel_wdata = pend_wdata_q;
            sel_be    = pend_be_q;
        end
    end

    generate
        if (DATA_W == 16) begin : g_lane16
            logic unused_lane16;
            assign wr_lanes      = {sel_wdata[7:0], sel_wdata[15:8]};
            assign mask_hi       = {~sel_be[0], ~sel_be[1]};
            assign rd_lane       = {rd_data[23:16], rd_data[31:24]};
            assign unused_lane16 = ^{sel_addr[0], a0_q, rd_data[15:0]};
        end else begin : g_lane8
            logic unused_lane8;
            assign wr_lanes     = {sel_wdata, sel_wdata};
            assign mask_hi      = sel_addr[0] ? 2'b10 : 2'b01;
            assign rd_lane      = a0_q ? rd_data[23:16] : rd_data[31:24];
            assign unused_lane8 = ^{sel_be, rd_data[15:0]};
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_wr_d      = pend_wr_q;
        pend_addr_d    = pend_addr_q;
        pend_wdata_d   = pend_wdata_q;
        pend_be_d      = pend_be_q;
        a0_d           = a0_q;
        cmd_d          = cmd_q;
        cmd_en_d       = 1'b0;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;
        data_mask_d    = data_mask_q;
        rdata_d        = '0;
        rdata_en_d     = 1'b0;
        timeout_err_d  = timeout_err_q;
        req_overrun_d  = req_overrun_q;

        if (issue_pend) begin
            pend_valid_d = 1'b0;
        end

        // A request landing in the cycle the slot drains takes the freed slot.
        if (store_req) begin
            if (slot_free) begin
                pend_valid_d = 1'b1;
                pend_wr_d    = wr;
                pend_addr_d  = address;
                pend_wdata_d = wdata;
                pend_be_d    = byte_en;
            end else begin
                req_overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            S_INIT: begin
                if (init_calib_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (issue) begin
                    cmd_en_d    = 1'b1;
                    cmd_d       = sel_wr;
                    addr_d      = sel_addr[ADDR_W-1:1];
                    wr_data_d   = {wr_lanes, 16'h0000};
                    data_mask_d = {mask_hi, 2'b11};
                    a0_d        = sel_addr[0];
                    if (sel_wr) begin
                        state_d = S_WR_WAIT;
                        cnt_d   = CNT_W'(WRITE_WAIT);
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = CNT_W'(READ_TIMEOUT);
                    end
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_WAIT: begin
                if (rd_data_valid) begin
                    rdata_d    = rd_lane;
                    rdata_en_d = 1'b1;
                    state_d    = S_RD_DRAIN;
                end else if (cnt_q == '0) begin
                    rdata_en_d    = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = S_RD_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_DRAIN: begin
                if (!rd_data_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        busy_d         = (state_d != S_IDLE) || pend_valid_d;
        initial_busy_d = (state_d == S_INIT);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= S_INIT;
            init_calib_q   <= 1'b0;
            busy_q         <= 1'b1;
            initial_busy_q <= 1'b1;
            cnt_q          <= '0;
            pend_valid_q   <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_addr_q    <= '0;
            pend_wdata_q   <= '0;
            pend_be_q      <= '0;
            a0_q           <= 1'b0;
            cmd_q          <= 1'b0;
            cmd_en_q       <= 1'b0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            data_mask_q    <= 4'hF;
            rdata_q        <= '0;
            rdata_en_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            req_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_calib_q   <= init_calib;
            busy_q         <= busy_d;
            initial_busy_q <= initial_busy_d;
            cnt_q          <= cnt_d;
            pend_valid_q   <= pend_valid_d;
            pend_wr_q      <= pend_wr_d;
            pend_addr_q    <= pend_addr_d;
            pend_wdata_q   <= pend_wdata_d;
            pend_be_q      <= pend_be_d;
            a0_q           <= a0_d;
            cmd_q          <= cmd_d;
            cmd_en_q       <= cmd_en_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            data_mask_q    <= data_mask_d;
            rdata_q        <= rdata_d;
            rdata_en_q     <= rdata_en_d;
            timeout_err_q  <= timeout_err_d;
            req_overrun_q  <= req_overrun_d;
        end
    end

    assign initial_busy = initial_busy_q;
    assign busy         = busy_q;
    assign rdata        = rdata_q;
    assign rdata_en     = rdata_en_q;
    assign timeout_err  = timeout_err_q;
    assign req_overrun  = req_overrun_q;
    assign cmd          = cmd_q;
    assign cmd_en       = cmd_en_q;
    assign addr         = addr_q;
    assign wr_data      = wr_data_q;
    assign data_mask    = data_mask_q;

endmodule
